acq_sequencer: RTL and testbench

Acquisition sequencer between the UART command path and the ADC/PSRAM memory driver. It decodes a 64-bit command frame and starts a capture of N 12-bit samples through the driver's write strobe. It then issues read strobes to refill the driver's FIFO and drains the FIFO into 24-bit UART frames, pacing each frame on the UART ready flag. It replaces ad-hoc sequencing in the board top level and adds sample accounting, busy/reject signalling and a wait-state watchdog.

---
 rtl/acq_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_acq_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/acq_sequencer.sv
// acq_sequencer: decodes a capture command, drives the ADC/PSRAM write/read strobes and drains the driver FIFO into UART frames.
// Ports:
//   clk_i, rst_n_i                   clock and synchronous active-low reset
//   cmd_frame_i/cmd_valid_i/cmd_error_i  command frame from the UART command path
//   cfg_*_o                          latched fields of the last accepted command
//   mem_ready_i, mem_size_add_o, mem_write_strobe_o, mem_read_strobe_o  memory driver handshake
//   fifo_data_i, fifo_empty_i, fifo_read_enable_o  driver FIFO drain port
//   tx_frame_o, tx_send_o, tx_ready_i  UART transmit handshake
//   busy_o, done_o, cmd_reject_o, timeout_err_o, led_n_o  status
module acq_sequencer #(
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd12_000_000,
   parameter int          GUARD_CYCLES   = 2
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [63:0] cmd_frame_i,
   input  logic        cmd_valid_i,
   input  logic        cmd_error_i,
   output logic [15:0] cfg_presamples_o,
   output logic [11:0] cfg_trigger_o,
   output logic [3:0]  cfg_trig_type_o,
   output logic [4:0]  cfg_frame_points_o,
   output logic [3:0]  cfg_processing_o,
   input  logic        mem_ready_i,
   output logic [22:0] mem_size_add_o,
   output logic        mem_write_strobe_o,
   output logic        mem_read_strobe_o,
   input  logic [23:0] fifo_data_i,
   input  logic        fifo_empty_i,
   output logic        fifo_read_enable_o,
   output logic [23:0] tx_frame_o,
   output logic        tx_send_o,
   input  logic        tx_ready_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        cmd_reject_o,
   output logic        timeout_err_o,
   output logic        led_n_o
);
   localparam logic [3:0] S_IDLE      = 4'd0;
   localparam logic [3:0] S_WR_REQ    = 4'd1;
   localparam logic [3:0] S_WR_WAIT   = 4'd2;
   localparam logic [3:0] S_RD_REQ    = 4'd3;
   localparam logic [3:0] S_RD_WAIT   = 4'd4;
   localparam logic [3:0] S_POP       = 4'd5;
   localparam logic [3:0] S_SEND      = 4'd6;
   localparam logic [3:0] S_SEND_WAIT = 4'd7;
   localparam logic [3:0] S_FINISH    = 4'd8;
   localparam logic [7:0] GUARD       = GUARD_CYCLES[7:0];

   logic [3:0]  state_q, state_d;
   logic [22:0] size_q, size_d, words_q, words_d, mem_size_q, mem_size_d;
   logic [23:0] wd_q, wd_d, tx_frame_q, tx_frame_d;
   logic [7:0]  guard_q, guard_d;
   logic [40:0] cfg_q, cfg_d;
   logic        wr_q, wr_d, rd_q, rd_d, pop_q, pop_d, send_q, send_d;
   logic        done_q, done_d, rej_q, rej_d, to_q, to_d, busy_q, busy_d;
   logic        guard_ok, wd_run, to;
   logic [22:0] cmd_size;

   assign cmd_size = cmd_frame_i[63:41];
   assign guard_ok = guard_q == 8'd0;
   assign wd_run   = state_q inside {S_WR_REQ, S_WR_WAIT, S_RD_REQ, S_RD_WAIT, S_POP, S_SEND_WAIT};
   assign to       = wd_run && (wd_q == TIMEOUT_CYCLES - 24'd1);

   always_comb begin
      state_d    = state_q;
      size_d     = size_q;
      words_d    = words_q;
      mem_size_d = mem_size_q;
      cfg_d      = cfg_q;
      tx_frame_d = tx_frame_q;
      guard_d    = guard_ok ? 8'd0 : guard_q - 8'd1;
      wr_d       = 1'b0;
      rd_d       = 1'b0;
      pop_d      = 1'b0;
      send_d     = 1'b0;
      rej_d      = cmd_valid_i && (state_q != S_IDLE);
      case (state_q)
         S_IDLE: if (cmd_valid_i && !cmd_error_i) begin
            if (cmd_size == 23'd0) rej_d = 1'b1;
            else begin
               size_d  = cmd_size;
               cfg_d   = cmd_frame_i[40:0];
               // widened by one bit so size=0x7FFFFF rounds up without wrapping
               words_d = 23'(({1'b0, cmd_size} + 24'd1) >> 1);
               state_d = S_WR_REQ;
            end
         end
         S_WR_REQ: if (mem_ready_i) begin
            wr_d       = 1'b1;
            mem_size_d = size_q;
            guard_d    = GUARD;
            state_d    = S_WR_WAIT;
         end
         S_WR_WAIT: if (guard_ok && mem_ready_i) state_d = S_RD_REQ;
         S_RD_REQ: if (mem_ready_i) begin
            rd_d       = 1'b1;
            mem_size_d = size_q;
            guard_d    = GUARD;
            state_d    = S_RD_WAIT;
         end
         S_RD_WAIT: if (guard_ok) state_d = !fifo_empty_i ? S_POP : mem_ready_i ? S_RD_REQ : S_RD_WAIT;
         S_POP:
            if (words_q == 23'd0) state_d = S_FINISH;
            else if (tx_ready_i && !fifo_empty_i) begin
               pop_d   = 1'b1;
               state_d = S_SEND;
            end
            else if (fifo_empty_i && mem_ready_i) state_d = S_RD_REQ;
         // the pop issued on entry makes fifo_data_i valid during this state
         S_SEND: begin
            tx_frame_d = fifo_data_i;
            send_d     = 1'b1;
            words_d    = words_q - 23'd1;
            guard_d    = GUARD;
            state_d    = S_SEND_WAIT;
         end
         S_SEND_WAIT: if (guard_ok && tx_ready_i) state_d = S_POP;
         S_FINISH: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (to) begin
         state_d = S_IDLE;
         wr_d    = 1'b0;
         rd_d    = 1'b0;
         pop_d   = 1'b0;
      end
      to_d   = to;
      done_d = state_d == S_FINISH;
      busy_d = state_d != S_IDLE;
      wd_d   = (state_d != state_q || !wd_run) ? 24'd0 : wd_q + 24'd1;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q    <= S_IDLE;
         size_q     <= '0;
         words_q    <= '0;
         mem_size_q <= '0;
         cfg_q      <= '0;
         tx_frame_q <= '0;
         guard_q    <= '0;
         wd_q       <= '0;
         wr_q       <= 1'b0;
         rd_q       <= 1'b0;
         pop_q      <= 1'b0;
         send_q     <= 1'b0;
         done_q     <= 1'b0;
         rej_q      <= 1'b0;
         to_q       <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         size_q     <= size_d;
         words_q    <= words_d;
         mem_size_q <= mem_size_d;
         cfg_q      <= cfg_d;
         tx_frame_q <= tx_frame_d;
         guard_q    <= guard_d;
         wd_q       <= wd_d;
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         pop_q      <= pop_d;
         send_q     <= send_d;
         done_q     <= done_d;
         rej_q      <= rej_d;
         to_q       <= to_d;
         busy_q     <= busy_d;
      end
   end

   assign {cfg_presamples_o, cfg_trigger_o, cfg_trig_type_o, cfg_frame_points_o, cfg_processing_o} = cfg_q;
   assign mem_size_add_o     = mem_size_q;
   assign mem_write_strobe_o = wr_q;
   assign mem_read_strobe_o  = rd_q;
   assign fifo_read_enable_o = pop_q;
   assign tx_frame_o         = tx_frame_q;
   assign tx_send_o          = send_q;
   assign busy_o             = busy_q;
   assign done_o             = done_q;
   assign cmd_reject_o       = rej_q;
   assign timeout_err_o      = to_q;
   assign led_n_o            = !busy_q;
endmodule

// File: tb/tb_acq_sequencer.sv
// tb_acq_sequencer: directed and randomized checks of acq_sequencer against a driver/FIFO/UART model.
module tb_acq_sequencer;
   localparam int GUARD = 2;
   localparam int TMO   = 100;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic [63:0] cmd_frame = '0;
   logic        cmd_valid = 1'b0, cmd_error = 1'b0;
   logic [15:0] cfg_presamples;
   logic [11:0] cfg_trigger;
   logic [3:0]  cfg_trig_type, cfg_processing;
   logic [4:0]  cfg_frame_points;
   logic        mem_ready = 1'b1;
   logic [22:0] mem_size_add;
   logic        mem_write_strobe, mem_read_strobe;
   logic [23:0] fifo_data = '0;
   logic        fifo_empty = 1'b1;
   logic        fifo_read_enable;
   logic [23:0] tx_frame;
   logic        tx_send, tx_ready = 1'b1;
   logic        busy, done, cmd_reject, timeout_err, led_n;

   acq_sequencer #(.TIMEOUT_CYCLES(24'(TMO)), .GUARD_CYCLES(GUARD)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .cmd_frame_i(cmd_frame), .cmd_valid_i(cmd_valid), .cmd_error_i(cmd_error),
      .cfg_presamples_o(cfg_presamples), .cfg_trigger_o(cfg_trigger), .cfg_trig_type_o(cfg_trig_type),
      .cfg_frame_points_o(cfg_frame_points), .cfg_processing_o(cfg_processing),
      .mem_ready_i(mem_ready), .mem_size_add_o(mem_size_add),
      .mem_write_strobe_o(mem_write_strobe), .mem_read_strobe_o(mem_read_strobe),
      .fifo_data_i(fifo_data), .fifo_empty_i(fifo_empty), .fifo_read_enable_o(fifo_read_enable),
      .tx_frame_o(tx_frame), .tx_send_o(tx_send), .tx_ready_i(tx_ready),
      .busy_o(busy), .done_o(done), .cmd_reject_o(cmd_reject), .timeout_err_o(timeout_err), .led_n_o(led_n)
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0, cyc = 0;
   int wr_cnt, rd_cnt, send_cnt, done_cnt, rej_cnt, to_cnt, busy_seen, min_gap, last_send, wr_cyc, to_cyc;
   int fifo_cap, fed, feed_total, seed;
   int consec_bad = 0, stb_not_ready = 0, pop_empty = 0, size_bad = 0;
   bit rand_rdy = 0, hold_low = 0, mem_low = 0;
   logic [40:0] exp_cfg = '0;
   logic [22:0] exp_size = '0;
   logic [23:0] fifoq[$];
   logic [3:0]  prev = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [23:0] word_of(input int n);
      return 24'(n * 40503 + seed);
   endfunction

   // driver, FIFO and UART model; inputs change mid-cycle so the DUT samples them stably
   always @(negedge clk) begin
      if (mem_write_strobe || mem_read_strobe) begin
         if (!mem_ready) stb_not_ready++;
         if (mem_size_add != exp_size) size_bad++;
      end
      if (mem_write_strobe) begin
         wr_cnt++;
         wr_cyc = cyc;
         if (hold_low) mem_low = 1;
      end
      if (mem_read_strobe) begin
         rd_cnt++;
         for (int i = 0; i < fifo_cap && fed < feed_total; i++) begin
            fifoq.push_back(word_of(fed));
            fed++;
         end
      end
      if ((prev & {mem_write_strobe, mem_read_strobe, fifo_read_enable, tx_send}) != 4'd0) consec_bad++;
      prev = {mem_write_strobe, mem_read_strobe, fifo_read_enable, tx_send};
      if (tx_send) begin
         check("frame", {40'd0, tx_frame}, {40'd0, word_of(send_cnt)});
         if (cyc - last_send < min_gap) min_gap = cyc - last_send;
         last_send = cyc;
         send_cnt++;
      end
      if (done) done_cnt++;
      if (cmd_reject) rej_cnt++;
      if (timeout_err) begin
         to_cnt++;
         to_cyc = cyc;
      end
      if (busy) busy_seen++;
      if (fifo_read_enable) begin
         if (fifoq.size() == 0) pop_empty++;
         else fifo_data = fifoq.pop_front();
      end else fifo_data = fifoq.size() != 0 ? fifoq[0] : 24'd0;
      fifo_empty = fifoq.size() == 0;
      mem_ready = !mem_low;
      tx_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
   end

   task automatic setup(input int cap, input bit rr);
      fifoq.delete();
      fed = 0; feed_total = 0; fifo_cap = cap; rand_rdy = rr; seed = int'($urandom);
      wr_cnt = 0; rd_cnt = 0; send_cnt = 0; done_cnt = 0; rej_cnt = 0; to_cnt = 0; busy_seen = 0;
      min_gap = 1000000; last_send = -1000; hold_low = 0; mem_low = 0;
   endtask

   task automatic send_cmd(input logic [22:0] size, input logic err, input bit accept);
      logic [40:0] f;
      f = 41'({$urandom(), $urandom()});
      if (accept) begin
         exp_cfg = f;
         exp_size = size;
         feed_total = (int'(size) + 1) / 2;
      end
      cmd_frame = {size, f};
      cmd_error = err;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_error = 1'b0;
      if (accept) begin
         check("busy_c1", {62'd0, busy, led_n}, 64'd2);
         @(negedge clk);
         check("wr_stb_c2", {40'd0, mem_write_strobe, mem_size_add}, {40'd0, 1'b1, size});
      end
   endtask

   task automatic wait_done(input string tag, input int budget);
      int d0;
      d0 = done_cnt;
      for (int i = 0; i < budget && done_cnt == d0; i++) @(negedge clk);
      check(tag, done_cnt, d0 + 1);
   endtask

   task automatic run_random(input string tag);
      int sz, w, cap;
      sz = int'($urandom_range(1, 80));
      cap = int'($urandom_range(1, 20));
      w = (sz + 1) / 2;
      setup(cap, 1);
      send_cmd(23'(sz), 1'b0, 1);
      wait_done({tag, "_done"}, 3000);
      check({tag, "_frames"}, send_cnt, w);
      check({tag, "_rd"}, rd_cnt, (w + cap - 1) / cap);
      check({tag, "_cfg"}, {23'd0, cfg_presamples, cfg_trigger, cfg_trig_type, cfg_frame_points, cfg_processing}, {23'd0, exp_cfg});
   endtask

   initial begin
      setup(1000, 0);
      repeat (3) @(negedge clk);
      check("rst_ctl", {55'd0, busy, led_n, done, cmd_reject, timeout_err, mem_write_strobe, mem_read_strobe, fifo_read_enable, tx_send}, 64'h080);
      check("rst_data", {17'd0, tx_frame, mem_size_add}, 64'd0);
      check("rst_cfg", {23'd0, cfg_presamples, cfg_trigger, cfg_trig_type, cfg_frame_points, cfg_processing}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // size 93, everything always ready
      setup(1000, 0);
      send_cmd(23'd93, 1'b0, 1);
      wait_done("t1_done", 2000);
      check("t1_wr", wr_cnt, 1);
      check("t1_rd", rd_cnt, 1);
      check("t1_frames", send_cnt, 47);
      check("t1_gap", min_gap >= GUARD + 1, 1);
      check("t1_cfg", {23'd0, cfg_presamples, cfg_trigger, cfg_trig_type, cfg_frame_points, cfg_processing}, {23'd0, exp_cfg});
      repeat (3) @(negedge clk);
      check("t1_idle", {62'd0, busy, led_n}, 64'd1);

      // size 0 rejected, error frame ignored
      setup(1000, 0);
      send_cmd(23'd0, 1'b0, 0);
      repeat (4) @(negedge clk);
      check("t2_rej", rej_cnt, 1);
      send_cmd(23'd7, 1'b1, 0);
      repeat (6) @(negedge clk);
      check("t2_err_norej", rej_cnt, 1);
      check("t2_nobusy", busy_seen, 0);
      check("t2_nostb", wr_cnt + rd_cnt, 0);
      check("t2_cfg_kept", {23'd0, cfg_presamples, cfg_trigger, cfg_trig_type, cfg_frame_points, cfg_processing}, {23'd0, exp_cfg});

      // 16-word FIFO, size 100: refills after each empty FIFO
      setup(16, 1);
      send_cmd(23'd100, 1'b0, 1);
      wait_done("t3_done", 4000);
      check("t3_frames", send_cnt, 50);
      check("t3_rd", rd_cnt, 4);
      check("t3_gap", min_gap >= GUARD + 1, 1);

      // second command mid-drain is rejected and does not disturb the first
      setup(8, 0);
      send_cmd(23'd40, 1'b0, 1);
      for (int i = 0; i < 500 && send_cnt < 5; i++) @(negedge clk);
      send_cmd(23'd5, 1'b0, 0);
      wait_done("t4_done", 2000);
      check("t4_rej", rej_cnt, 1);
      check("t4_frames", send_cnt, 20);
      check("t4_cfg", {23'd0, cfg_presamples, cfg_trigger, cfg_trig_type, cfg_frame_points, cfg_processing}, {23'd0, exp_cfg});

      // mem_ready stuck low after the write strobe
      setup(1000, 0);
      hold_low = 1;
      send_cmd(23'd10, 1'b0, 1);
      for (int i = 0; i < 400 && to_cnt == 0; i++) @(negedge clk);
      check("t5_to", to_cnt, 1);
      check("t5_to_cycles", to_cyc - wr_cyc, TMO);
      check("t5_busy", {62'd0, busy, led_n}, 64'd1);
      check("t5_nodone", done_cnt, 0);
      hold_low = 0;
      mem_low = 0;
      repeat (2) @(negedge clk);
      run_random("t5_after");

      // reset during SEND_WAIT
      setup(1000, 0);
      send_cmd(23'd30, 1'b0, 1);
      for (int i = 0; i < 500 && !tx_send; i++) @(negedge clk);
      check("t6_in_send_wait", tx_send, 1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("t6_rst_ctl", {55'd0, busy, led_n, done, cmd_reject, timeout_err, mem_write_strobe, mem_read_strobe, fifo_read_enable, tx_send}, 64'h080);
      check("t6_rst_data", {17'd0, tx_frame, mem_size_add}, 64'd0);
      check("t6_rst_cfg", {23'd0, cfg_presamples, cfg_trigger, cfg_trig_type, cfg_frame_points, cfg_processing}, 64'd0);
      begin
         int s0;
         s0 = send_cnt;
         repeat (60) @(negedge clk);
         check("t6_no_more_send", send_cnt, s0);
      end
      check("t6_idle", busy, 0);

      // randomized commands
      for (int k = 0; k < 3; k++) run_random("rnd");

      check("no_consec_pulse", consec_bad, 0);
      check("no_stb_not_ready", stb_not_ready, 0);
      check("no_pop_empty", pop_empty, 0);
      check("stb_size", size_bad, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
